// File: rtl/sol_pkg.sv
// Shared types and register/status field positions
// for the solenoid drive sequencer.
package sol_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PULLIN = 2'd1,
    S_HOLD   = 2'd2,
    S_FAULT  = 2'd3
  } sol_state_e;

  localparam int EN_BIT        = 0;
  localparam int FCLR_BIT      = 1;
  localparam int HOLD_DUTY_LSB = 16;

  localparam int ST_STATE_LSB  = 0;
  localparam int ST_LATCH_BIT  = 2;
  localparam int ST_SOL_BIT    = 3;
  localparam int ST_FCNT_LSB   = 8;

endpackage

// File: rtl/sol_pwm_gen.sv
// PWM period counter with shadowed period/duty,
// loaded only on the load strobe from the sequencer.
module sol_pwm_gen
  import sol_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] duty_in,
  output logic             pwm_on,
  output logic             period_end,
  output logic             period_zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;

  assign period_zero = (period_sh == '0);

  // >= keeps a shrunken period from running the counter to wrap
  assign period_end = run && !period_zero &&
                      (cnt >= period_sh - ONE);

  assign pwm_on = !period_zero && (cnt < duty_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
    end else begin
      if (load) begin
        period_sh <= period_in;
        duty_sh   <= duty_in;
      end
      if (!run || period_zero || period_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/sol_drive_ctrl.sv
// Solenoid pull-in/hold sequencer: FSM, over-current
// synchroniser, pull-in period counter and status word.
module sol_drive_ctrl
  import sol_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] slv_reg0,
  input  logic [31:0] slv_reg1,
  input  logic [31:0] slv_reg2,
  input  logic [31:0] slv_reg3,
  input  logic        oc_in,
  output logic        sol_out,
  output logic [31:0] status
);

  localparam logic [CNT_W-1:0]  ONE  = CNT_W'(1);
  localparam logic [FCNT_W-1:0] FONE = FCNT_W'(1);

  sol_state_e        state, state_n;
  logic              s1, oc_s;
  logic [CNT_W-1:0]  pcnt, pcnt_n;
  logic              latched, latched_n;
  logic [FCNT_W-1:0] fcnt, fcnt_n;
  logic              load, use_hold, run;
  logic              pwm_on, period_end, period_zero;
  logic              en, fclr;
  logic [CNT_W-1:0]  pull_duty, hold_duty, duty_in;
  logic [31:0]       status_n;
  logic              unused_regs;

  assign en        = slv_reg0[EN_BIT];
  assign fclr      = slv_reg0[FCLR_BIT];
  assign pull_duty = slv_reg2[CNT_W-1:0];
  assign hold_duty = slv_reg2[HOLD_DUTY_LSB +: CNT_W];
  assign duty_in   = use_hold ? hold_duty : pull_duty;
  assign run       = (state == S_PULLIN) ||
                     (state == S_HOLD);

  assign unused_regs = ^{slv_reg0, slv_reg1,
                         slv_reg2, slv_reg3};

  sol_pwm_gen #(.CNT_W(CNT_W)) u_pwm (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .run         (run),
    .load        (load),
    .period_in   (slv_reg1[CNT_W-1:0]),
    .duty_in     (duty_in),
    .pwm_on      (pwm_on),
    .period_end  (period_end),
    .period_zero (period_zero)
  );

  always_comb begin
    state_n   = state;
    pcnt_n    = pcnt;
    latched_n = latched;
    fcnt_n    = fcnt;
    load      = 1'b0;
    use_hold  = 1'b1;
    // over-current wins over every enable decision
    if (oc_s && state != S_FAULT) begin
      state_n   = S_FAULT;
      latched_n = 1'b1;
      if (fcnt != '1) fcnt_n = fcnt + FONE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en) begin
            state_n  = S_PULLIN;
            load     = 1'b1;
            use_hold = 1'b0;
            pcnt_n   = slv_reg3[CNT_W-1:0];
          end
        end
        S_PULLIN: begin
          use_hold = 1'b0;
          if (!en) begin
            state_n = S_IDLE;
          end else if (pcnt == '0) begin
            state_n  = S_HOLD;
            load     = 1'b1;
            use_hold = 1'b1;
          end else if (period_end) begin
            pcnt_n = pcnt - ONE;
            if (pcnt == ONE) begin
              state_n  = S_HOLD;
              load     = 1'b1;
              use_hold = 1'b1;
            end
          end else if (period_zero) begin
            load = 1'b1;
          end
        end
        S_HOLD: begin
          if (!en) begin
            state_n = S_IDLE;
          end else if (period_end || period_zero) begin
            load = 1'b1;
          end
        end
        S_FAULT: begin
          if (fclr && !en && !oc_s) begin
            state_n   = S_IDLE;
            latched_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status_n = '0;
    status_n[ST_STATE_LSB +: 2]     = state;
    status_n[ST_LATCH_BIT]          = latched;
    status_n[ST_SOL_BIT]            = sol_out;
    status_n[ST_FCNT_LSB +: FCNT_W] = fcnt;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state   <= S_IDLE;
      s1      <= 1'b0;
      oc_s    <= 1'b0;
      pcnt    <= '0;
      latched <= 1'b0;
      fcnt    <= '0;
      sol_out <= 1'b0;
      status  <= '0;
    end else begin
      state   <= state_n;
      s1      <= oc_in;
      oc_s    <= s1;
      pcnt    <= pcnt_n;
      latched <= latched_n;
      fcnt    <= fcnt_n;
      sol_out <= run && pwm_on && !oc_s;
      status  <= status_n;
    end
  end

endmodule

// File: tb/tb_sol_drive_ctrl.sv
// Self-checking bench for sol_drive_ctrl: vector table,
// directed corner sequences and random stimulus vs. a model.
module tb_sol_drive_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic        oc_in;
  logic        sol_out;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;
  int hi_cnt [8];

  // reference model: phase 0..3, position in period, shadows
  int m_st, m_s1, m_oc, m_pos, m_per, m_duty;
  int m_left, m_latch, m_fcnt, m_out;
  logic [31:0] m_status;

  typedef struct {
    int per;
    int pull;
    int hold;
    int npull;
    int exp_pull;
    int exp_hold;
  } vec_t;

  vec_t vt [6];

  sol_drive_ctrl dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .slv_reg0 (slv_reg0),
    .slv_reg1 (slv_reg1),
    .slv_reg2 (slv_reg2),
    .slv_reg3 (slv_reg3),
    .oc_in    (oc_in),
    .sol_out  (sol_out),
    .status   (status)
  );

  always #5 ACLK = ~ACLK;

  task automatic model_reset();
    m_st = 0; m_s1 = 0; m_oc = 0; m_pos = 0;
    m_per = 0; m_duty = 0; m_left = 0;
    m_latch = 0; m_fcnt = 0; m_out = 0;
    m_status = 32'd0;
  endtask

  task automatic model_step();
    int st, pos, per, duty, left, latch, fcnt, out;
    int rp, rpull, rhold, rn;
    bit en, clr, active, wrap;
    if (!ARESETN) begin
      model_reset();
      return;
    end
    en    = slv_reg0[0];
    clr   = slv_reg0[1];
    rp    = int'(slv_reg1[15:0]);
    rpull = int'(slv_reg2[15:0]);
    rhold = int'(slv_reg2[31:16]);
    rn    = int'(slv_reg3[15:0]);
    active = (m_st == 1) || (m_st == 2);
    wrap = active && m_per > 0 && (m_pos + 1 >= m_per);
    out = (active && m_per > 0 && m_pos < m_duty
           && m_oc == 0) ? 1 : 0;
    pos = (active && m_per > 0 && !wrap) ? m_pos + 1 : 0;
    st = m_st; per = m_per; duty = m_duty;
    left = m_left; latch = m_latch; fcnt = m_fcnt;
    if (m_oc != 0 && m_st != 3) begin
      st = 3; latch = 1;
      fcnt = (m_fcnt >= 255) ? 255 : m_fcnt + 1;
    end else begin
      case (m_st)
        0: if (en) begin
          st = 1; per = rp; duty = rpull; left = rn;
        end
        1: if (!en) st = 0;
        else if (m_left == 0) begin
          st = 2; per = rp; duty = rhold;
        end else if (wrap) begin
          left = m_left - 1;
          if (left == 0) begin
            st = 2; per = rp; duty = rhold;
          end
        end else if (m_per == 0) begin
          per = rp; duty = rpull;
        end
        2: if (!en) st = 0;
        else if (wrap || m_per == 0) begin
          per = rp; duty = rhold;
        end
        default: if (clr && !en && m_oc == 0) begin
          st = 0; latch = 0;
        end
      endcase
    end
    m_status = 32'(m_fcnt << 8) | 32'(m_out << 3) |
               32'(m_latch << 2) | 32'(m_st);
    m_oc = m_s1;
    m_s1 = oc_in ? 1 : 0;
    m_st = st; m_pos = pos; m_per = per; m_duty = duty;
    m_left = left; m_latch = latch; m_fcnt = fcnt;
    m_out = out;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_step();
    #1;
    check("model_sol_out", {31'd0, sol_out}, 32'(m_out));
    check("model_status", status, m_status);
  endtask

  task automatic apply_reset();
    ARESETN  = 1'b0;
    model_reset();
    slv_reg0 = 32'd0;
    oc_in    = 1'b0;
    tick();
    tick();
    ARESETN  = 1'b1;
  endtask

  task automatic measure(input int per, input int nper);
    for (int p = 0; p < 8; p++) hi_cnt[p] = 0;
    for (int i = 0; i < per * nper; i++) begin
      if (sol_out) hi_cnt[i / per]++;
      tick();
    end
  endtask

  initial begin
    vt[0] = '{10, 8, 3, 2, 8, 3};
    vt[1] = '{10, 8, 3, 0, 0, 3};
    vt[2] = '{ 5, 0, 2, 1, 0, 2};
    vt[3] = '{ 4, 9, 4, 1, 4, 4};
    vt[4] = '{ 6, 3, 0, 3, 3, 0};
    vt[5] = '{ 1, 1, 1, 2, 1, 1};

    ARESETN  = 1'b0;
    slv_reg0 = 32'd0;
    slv_reg1 = 32'd0;
    slv_reg2 = 32'd0;
    slv_reg3 = 32'd0;
    oc_in    = 1'b0;
    model_reset();
    #2;
    check("reset_sol_out", {31'd0, sol_out}, 32'd0);
    check("reset_status", status, 32'd0);
    tick();
    tick();
    ARESETN = 1'b1;

    // period/duty table
    for (int v = 0; v < 6; v++) begin
      apply_reset();
      slv_reg1 = 32'(vt[v].per);
      slv_reg2 = {16'(vt[v].hold), 16'(vt[v].pull)};
      slv_reg3 = 32'(vt[v].npull);
      tick();
      slv_reg0 = 32'h1;
      tick();
      check("first_edge_low", {31'd0, sol_out}, 32'd0);
      tick();
      measure(vt[v].per, vt[v].npull + 2);
      for (int p = 0; p < vt[v].npull + 2; p++) begin
        if (p < vt[v].npull)
          check("pull_high_cnt", 32'(hi_cnt[p]),
                32'(vt[v].exp_pull));
        else
          check("hold_high_cnt", 32'(hi_cnt[p]),
                32'(vt[v].exp_hold));
      end
      check("in_hold", status & 32'h3, 32'd2);
    end

    // hold duty written mid-period
    apply_reset();
    slv_reg1 = 32'd10;
    slv_reg2 = {16'd3, 16'd8};
    slv_reg3 = 32'd0;
    tick();
    slv_reg0 = 32'h1;
    tick();
    tick();
    for (int p = 0; p < 8; p++) hi_cnt[p] = 0;
    for (int i = 0; i < 20; i++) begin
      if (sol_out) hi_cnt[i / 10]++;
      if (i == 4) slv_reg2 = {16'd12, 16'd8};
      tick();
    end
    check("hold_keep_cur", 32'(hi_cnt[0]), 32'd3);
    check("hold_next_full", 32'(hi_cnt[1]), 32'd10);

    // one-cycle over-current pulse in hold
    oc_in = 1'b1;
    tick();
    oc_in = 1'b0;
    tick();
    tick();
    check("fault_response", {31'd0, sol_out}, 32'd0);
    tick();
    check("fault_status", status, 32'h0000_0107);
    slv_reg0 = 32'h3;
    tick();
    tick();
    tick();
    check("fclr_ignored", status & 32'h3, 32'd3);
    slv_reg0 = 32'h2;
    tick();
    tick();
    check("fault_exit", status, 32'h0000_0100);
    slv_reg0 = 32'h0;

    // zero period stalls pull-in
    apply_reset();
    slv_reg1 = 32'd0;
    slv_reg2 = {16'd3, 16'd8};
    slv_reg3 = 32'd2;
    tick();
    slv_reg0 = 32'h1;
    for (int i = 0; i < 10; i++) tick();
    check("zero_per_off", {31'd0, sol_out}, 32'd0);
    check("zero_per_pullin", status & 32'h3, 32'd1);
    slv_reg1 = 32'd4;
    tick();
    check("per_load_low", {31'd0, sol_out}, 32'd0);
    tick();
    check("per_start", {31'd0, sol_out}, 32'd1);

    // async reset mid pull-in, then full restart
    apply_reset();
    slv_reg1 = 32'd10;
    slv_reg2 = {16'd3, 16'd8};
    slv_reg3 = 32'd2;
    tick();
    slv_reg0 = 32'h1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_on", {31'd0, sol_out}, 32'd1);
    #2;
    ARESETN = 1'b0;
    model_reset();
    #1;
    check("async_sol_out", {31'd0, sol_out}, 32'd0);
    check("async_status", status, 32'd0);
    tick();
    ARESETN = 1'b1;
    tick();
    tick();
    measure(10, 3);
    check("restart_pull0", 32'(hi_cnt[0]), 32'd8);
    check("restart_pull1", 32'(hi_cnt[1]), 32'd8);
    check("restart_hold", 32'(hi_cnt[2]), 32'd3);

    // fault counter saturation
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      oc_in = 1'b1;
      tick();
      oc_in = 1'b0;
      tick();
      tick();
      slv_reg0 = 32'h2;
      tick();
      slv_reg0 = 32'h0;
    end
    tick();
    check("fcnt_saturate", (status >> 8) & 32'hFF, 32'hFF);

    // random stimulus against the model
    apply_reset();
    slv_reg1 = 32'd6;
    slv_reg2 = {16'd2, 16'd5};
    slv_reg3 = 32'd1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0)
        slv_reg1 = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0)
        slv_reg2 = {16'($urandom_range(0, 14)),
                    16'($urandom_range(0, 14))};
      if ($urandom_range(0, 29) == 0)
        slv_reg3 = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0)
        slv_reg0 = 32'($urandom_range(0, 3));
      oc_in = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sol_drive_ctrl.md
Name: sol_drive_ctrl

Overview:
- Single-channel solenoid drive sequencer.
- Sits directly downstream of the SOL_regs AXI4-Lite register slave. It consumes the four 32-bit control registers and generates a pull-in/hold PWM gate signal for one solenoid driver.
- Latches over-current faults and returns a status word to the register block for readback.
- Fully synchronous to the AXI clock, so no CDC is needed on the register inputs.

Parameters:
- CNT_W, 16, width of the PWM period, duty and pull-in period counters.
- FCNT_W, 8, width of the saturating fault counter.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset.
- slv_reg0  in  32  control: [0] enable, [1] fault_clr (level; acted on only in FAULT with enable=0).
- slv_reg1  in  32  [CNT_W-1:0] PWM period in ACLK cycles.
- slv_reg2  in  32  [CNT_W-1:0] pull-in duty, [16+CNT_W-1:16] hold duty (ACLK cycles high per period).
- slv_reg3  in  32  [CNT_W-1:0] pull-in duration in whole PWM periods.
- oc_in  in  1  over-current comparator, asynchronous, active-high.
- sol_out  out  1  gate drive, registered.
- status  out  32  [1:0] state, [2] fault_latched, [3] sol_out, [15:8] fault_cnt, other bits 0.

Interface: one clock, ACLK. Reset ARESETN is asynchronous and active-low. All state, including the oc_in synchroniser, clears asynchronously when ARESETN=0.

Behaviour:
- Reset values:
  - sol_out=0; state=IDLE; all counters=0; shadow registers=0.
  - status=0; fault_cnt=0; synchroniser flops=0.
- oc_in passes through a 2-FF synchroniser to give oc_s. A rising oc_in sampled at edge k gives oc_s=1 after edge k+1.
- States (2-bit encoding): IDLE=0, PULLIN=1, HOLD=2, FAULT=3.
- IDLE:
  - When enable=1 and oc_s=0 -> PULLIN.
  - On that transition: load period_sh←reg1, duty_sh←pull-in duty, pcnt←reg3; pwm_cnt←0.
- PULLIN:
  - At each period end (pwm_cnt==period_sh-1), decrement pcnt.
  - When pcnt reaches 0 at a period end, or when pcnt==0 on entry -> HOLD. Entry with pcnt==0 moves to HOLD on the next edge with no pull-in period.
  - On entering HOLD, reload period_sh←reg1 and duty_sh←hold duty.
- HOLD:
  - Remains while enable=1.
  - Reloads period_sh and duty_sh at each period end, so register writes take effect only on period boundaries and never mid-period.
- Any of IDLE/PULLIN/HOLD with oc_s=1 -> FAULT:
  - set fault_latched;
  - fault_cnt+1, saturating at all-ones.
  - oc_s has priority over enable.
- PULLIN or HOLD with enable=0 and oc_s=0 -> IDLE.
- FAULT: exits to IDLE only when fault_clr=1, enable=0 and oc_s=0. Exit clears fault_latched; fault_cnt is retained.
- PWM:
  - pwm_cnt counts 0..period_sh-1 and wraps to 0.
  - Next sol_out = (state in {PULLIN,HOLD}) && pwm_cnt < duty_sh && !oc_s.
  - duty_sh ≥ period_sh gives 100% on; duty_sh=0 gives always off.
  - period_sh=0: pwm_cnt holds at 0, sol_out=0, and no period end occurs, so PULLIN stalls until reg1 becomes nonzero (reloaded each cycle while period_sh=0).
- Latency:
  - enable rising at edge N -> state=PULLIN after edge N+1 -> sol_out=1 after edge N+2, provided pull-in duty>0.
  - enable falling -> sol_out=0 two edges later.
  - oc_in -> sol_out=0 and state=FAULT after edge k+2; this is the required maximum fault response of 3 ACLK edges from sampling.
- status is registered and updated every cycle; it lags state by 1 cycle.
- Async reset mid-period forces sol_out=0 immediately. No pull-in resume after reset.

Decomposition:
- Package sol_pkg holds:
  - sol_state_e enum with encodings as above;
  - register bit-position constants (EN_BIT=0, FCLR_BIT=1, HOLD_DUTY_LSB=16);
  - status field positions.
- Sub-module sol_pwm_gen contains the period counter, shadow load strobe input, compare output and period_end output.
- The top holds the FSM, the synchroniser, the pull-in counter and the status logic.

Test Plan:
- reg1=10, reg2={hold=3,pull=8}, reg3=2, set enable -> sol_out: 2 periods of 8 high/2 low, then 3 high/7 low repeating; status[1:0] goes 1 then 2; first sol_out=1 exactly 2 edges after the enable write.
- reg3=0 with the same setup -> no pull-in period; the first period after enable is 3 high/7 low.
- While in HOLD, write hold duty=12 mid-period -> current period keeps 3 high; the next period is 100% high (12≥10).
- oc_in pulse of 1 cycle while in HOLD -> sol_out=0 within 3 edges; status=0x0000_0107 (state 3, latched, fault_cnt=1); fault_clr with enable=1 ignored; enable=0 plus fault_clr -> IDLE, status[2]=0, fault_cnt stays 1.
- reg1=0 with enable=1 -> sol_out stays 0 and state stays PULLIN; write reg1=4 -> PWM starts on the following cycle.
- Assert ARESETN=0 mid-pulse in PULLIN -> sol_out and status=0 asynchronously; after release with enable still 1, the sequence restarts with a full pull-in.
